// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multi-cycle RV32 controller.
// Optional feature macro: MC_CTRL_TRAP_EN (adds the TRAP state for illegal opcodes).
package ctrl_pkg;

   // Controller states; the FSM itself stores these as plain 3-bit constants.
   typedef enum logic [2:0] {
      ST_RST    = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_t;

   // Instruction classes the sequencer distinguishes.
   typedef enum logic [2:0] {
      OC_R   = 3'd0,
      OC_I   = 3'd1,
      OC_LD  = 3'd2,
      OC_ST  = 3'd3,
      OC_BR  = 3'd4,
      OC_JAL = 3'd5,
      OC_ILL = 3'd6
   } op_class_t;

   // Major opcodes (IR[6:0]).
   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_I   = 7'b0010011;
   localparam logic [6:0] OPC_LD  = 7'b0000011;
   localparam logic [6:0] OPC_ST  = 7'b0100011;
   localparam logic [6:0] OPC_BR  = 7'b1100011;
   localparam logic [6:0] OPC_JAL = 7'b1101111;

   // ALU operation classes.
   localparam logic [2:0] ALU_OP_R    = 3'b000;
   localparam logic [2:0] ALU_OP_I    = 3'b001;
   localparam logic [2:0] ALU_OP_ADDR = 3'b010;
   localparam logic [2:0] ALU_OP_BR   = 3'b011;
   localparam logic [2:0] ALU_OP_PC   = 3'b101;

   // PC source select.
   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   // ALU operand selects.
   localparam logic       ALU_A_PC   = 1'b0;
   localparam logic       ALU_A_RS1  = 1'b1;
   localparam logic [1:0] ALU_B_RS2  = 2'b00;
   localparam logic [1:0] ALU_B_FOUR = 2'b01;
   localparam logic [1:0] ALU_B_IMM  = 2'b10;
   localparam logic [1:0] ALU_B_BOFF = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bundle between the sequencer and the datapath/memory.
//
// Memory handshake: mem_req is held high (with iord and mem_we stable) for
// every cycle of an access; the access completes in the cycle where
// mem_ready=1 while mem_req=1. mem_ready is don't-care when mem_req=0.
interface multicycle_ctrl_if;
   logic [6:0] opcode;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_we;
   logic       iord;
   logic       ir_write;
   logic       pc_write;
   logic       pc_write_cond;
   logic [1:0] pc_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic       reg_write;
   logic       mem_to_reg;
   logic       instr_done;
   logic       trap;

   // Controller side.
   modport master (
      input  opcode, mem_ready,
      output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
             alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, instr_done, trap
   );

   // Datapath / memory side.
   modport slave (
      output opcode, mem_ready,
      input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
             alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, instr_done, trap
   );
endinterface

// File: rtl/multicycle_ctrl_op_class_decode.sv
// op_class_decode: combinational major-opcode to instruction-class decoder.
module op_class_decode
   import ctrl_pkg::*;
(
   input  logic [6:0] opcode_i,
   output op_class_t  op_class_o
);

   // Map the major opcode onto one of the sequencer's classes.
   always_comb begin
      case (opcode_i)
         OPC_R:   op_class_o = OC_R;
         OPC_I:   op_class_o = OC_I;
         OPC_LD:  op_class_o = OC_LD;
         OPC_ST:  op_class_o = OC_ST;
         OPC_BR:  op_class_o = OC_BR;
         OPC_JAL: op_class_o = OC_JAL;
         default: op_class_o = OC_ILL;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer driving the RV32 datapath.
// Optional feature macro: MC_CTRL_TRAP_EN -- illegal opcodes park the FSM in
// TRAP with trap=1 until reset; without it they retire as a two-cycle NOP.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_ctrl_if.master    bus,
   output logic [INSTRET_W-1:0] instret,
   output state_t               dbg_state
);

   localparam logic [2:0] S_RST    = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
`ifdef MC_CTRL_TRAP_EN
   localparam logic [2:0] S_TRAP   = 3'd6;
`endif

   logic [2:0]           state_q, state_d;
   op_class_t            op_class_q, op_class_d;
   op_class_t            dec_class;
   logic [INSTRET_W-1:0] instret_q;

   logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
   logic [1:0] pc_src, alu_src_b;
   logic       alu_src_a, reg_write, mem_to_reg, instr_done, trap;
   logic [2:0] alu_op;

   op_class_decode u_dec (
      .opcode_i   (bus.opcode),
      .op_class_o (dec_class)
   );

   // State, latched class and retire counter; reset aborts any instruction at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_RST;
         op_class_q <= OC_ILL;
         instret_q  <= '0;
      end else begin
         state_q    <= state_d;
         op_class_q <= op_class_d;
         if (instr_done) instret_q <= instret_q + 1'b1;
      end
   end

   // Next state and control outputs; everything not driven in a state stays 0.
   always_comb begin
      state_d       = state_q;
      op_class_d    = op_class_q;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = PC_SRC_ALU;
      alu_src_a     = ALU_A_PC;
      alu_src_b     = ALU_B_RS2;
      alu_op        = ALU_OP_R;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      instr_done    = 1'b0;
      trap          = 1'b0;

      case (state_q)
         S_RST: begin
            state_d = S_FETCH;
         end

         S_FETCH: begin
            mem_req   = 1'b1;
            iord      = 1'b0;
            alu_src_a = ALU_A_PC;
            alu_src_b = ALU_B_FOUR;
            alu_op    = ALU_OP_PC;
            pc_src    = PC_SRC_ALU;
            if (bus.mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end

         S_DECODE: begin
            // ALU precomputes the branch target while the class is latched.
            alu_src_a  = ALU_A_PC;
            alu_src_b  = ALU_B_BOFF;
            alu_op     = ALU_OP_PC;
            op_class_d = dec_class;
            if (dec_class == OC_ILL) begin
`ifdef MC_CTRL_TRAP_EN
               state_d = S_TRAP;
`else
               instr_done = 1'b1;
               state_d    = S_FETCH;
`endif
            end else begin
               state_d = S_EXEC;
            end
         end

         S_EXEC: begin
            case (op_class_q)
               OC_R: begin
                  alu_src_a = ALU_A_RS1;
                  alu_src_b = ALU_B_RS2;
                  alu_op    = ALU_OP_R;
                  state_d   = S_WB;
               end
               OC_I: begin
                  alu_src_b = ALU_B_IMM;
                  alu_op    = ALU_OP_I;
                  state_d   = S_WB;
               end
               OC_LD, OC_ST: begin
                  alu_src_b = ALU_B_IMM;
                  alu_op    = ALU_OP_ADDR;
                  state_d   = S_MEM;
               end
               OC_BR: begin
                  alu_src_b     = ALU_B_RS2;
                  alu_op        = ALU_OP_BR;
                  pc_write_cond = 1'b1;
                  pc_src        = PC_SRC_ALUOUT;
                  instr_done    = 1'b1;
                  state_d       = S_FETCH;
               end
               OC_JAL: begin
                  // No link register write in this core.
                  pc_write   = 1'b1;
                  pc_src     = PC_SRC_JUMP;
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end
               default: begin
                  state_d = S_FETCH;
               end
            endcase
         end

         S_MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            mem_we  = (op_class_q == OC_ST);
            if (bus.mem_ready) begin
               if (op_class_q == OC_ST) begin
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end

         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (op_class_q == OC_LD);
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end

`ifdef MC_CTRL_TRAP_EN
         S_TRAP: begin
            // Parked until reset; nothing else is driven.
            trap = 1'b1;
         end
`endif

         default: begin
            state_d = S_RST;
         end
      endcase
   end

   assign bus.mem_req       = mem_req;
   assign bus.mem_we        = mem_we;
   assign bus.iord          = iord;
   assign bus.ir_write      = ir_write;
   assign bus.pc_write      = pc_write;
   assign bus.pc_write_cond = pc_write_cond;
   assign bus.pc_src        = pc_src;
   assign bus.alu_src_a     = alu_src_a;
   assign bus.alu_src_b     = alu_src_b;
   assign bus.alu_op        = alu_op;
   assign bus.reg_write     = reg_write;
   assign bus.mem_to_reg    = mem_to_reg;
   assign bus.instr_done    = instr_done;
   assign bus.trap          = trap;

   assign instret   = instret_q;
   assign dbg_state = state_t'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: vector table, randomized reference-model run and
// reset-abort sequence for multicycle_ctrl (honours MC_CTRL_TRAP_EN).
module tb_multicycle_ctrl;
   import ctrl_pkg::*;

   localparam int IW = 4;  // narrow counter so the random run wraps it

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [IW-1:0] instret;
   state_t        dbg_state;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(.INSTRET_W(IW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .instret   (instret),
      .dbg_state (dbg_state)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   // Packed view of all control outputs:
   // {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src[1:0],
   //  alu_src_a, alu_src_b[1:0], alu_op[2:0], reg_write, mem_to_reg, instr_done, trap}
   logic [17:0] act;
   assign act = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
                 bus.pc_write_cond, bus.pc_src, bus.alu_src_a, bus.alu_src_b,
                 bus.alu_op, bus.reg_write, bus.mem_to_reg, bus.instr_done, bus.trap};

   int checks = 0;
   int errors = 0;
   logic [IW-1:0] exp_ir;

   // Scoreboard helpers
   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, a, e);
      end
   endtask

   task automatic chk1(input string name, input logic a, input logic e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b", name, a, e);
      end
   endtask

   // Expected-output constructors, written directly from the per-state output lists
   function automatic logic [17:0] o_fetch(input logic r);
      return {1'b1, 1'b0, 1'b0, r, r, 1'b0, 2'b00, 1'b0, 2'b01, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0};
   endfunction

   function automatic logic [17:0] o_dec(input logic done);
      return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 3'b101, 1'b0, 1'b0, done, 1'b0};
   endfunction

   function automatic logic [17:0] o_exec(input logic asa, input logic [1:0] asb, input logic [2:0] op,
                                          input logic pw, input logic pwc, input logic [1:0] ps,
                                          input logic done);
      return {1'b0, 1'b0, 1'b0, 1'b0, pw, pwc, ps, asa, asb, op, 1'b0, 1'b0, done, 1'b0};
   endfunction

   function automatic logic [17:0] o_mem(input logic we, input logic done);
      return {1'b1, we, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, done, 1'b0};
   endfunction

   function automatic logic [17:0] o_wb(input logic m2r);
      return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b1, m2r, 1'b1, 1'b0};
   endfunction

   // Vector table
   typedef struct {
      logic [6:0]  opc;
      logic        rdy;
      logic [17:0] exp;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [6:0] opc, input logic rdy, input logic [17:0] e);
      tbl.push_back('{opc, rdy, e});
   endtask

   // Driver: reset
   task automatic do_reset();
      @(negedge clk);
      rst_n         = 1'b0;
      bus.opcode    = 7'd0;
      bus.mem_ready = 1'b0;
      #1;
      chk("rst_outputs", 32'(act), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(ST_RST));
      chk("rst_instret", 32'(instret), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_release_outputs", 32'(act), 32'd0);
      exp_ir = '0;
   endtask

   // Driver + model: one instruction with fw FETCH stalls and mw MEM stalls.
   // Expectations come from the latency rules: base cycles per class plus one per stall.
   task automatic run_instr(input logic [6:0] opc, input int fw, input int mw_in);
      int  base, total, ms, me, mw;
      bit  is_ld, is_st, is_mem, wr;
      is_ld  = (opc == 7'b0000011);
      is_st  = (opc == 7'b0100011);
      is_mem = is_ld || is_st;
      wr     = (opc == 7'b0110011) || (opc == 7'b0010011) || is_ld;
      if (is_ld) base = 5;
      else if ((opc == 7'b0110011) || (opc == 7'b0010011) || is_st) base = 4;
      else if ((opc == 7'b1100011) || (opc == 7'b1101111)) base = 3;
      else base = 2;
      mw    = is_mem ? mw_in : 0;
      total = base + fw + mw;
      ms    = fw + 3;
      me    = fw + 3 + mw;
      for (int k = 0; k < total; k++) begin
         bit in_f, in_m, last;
         in_f = (k <= fw);
         in_m = is_mem && (k >= ms) && (k <= me);
         last = (k == total - 1);
         @(negedge clk);
         bus.opcode = opc;
         if (in_f)      bus.mem_ready = (k == fw);
         else if (in_m) bus.mem_ready = (k == me);
         else           bus.mem_ready = 1'($urandom_range(0, 1));
         #1;
         if (k == 0) chk("rnd_instret", 32'(instret), 32'(exp_ir));
         chk1("rnd_mem_req", bus.mem_req, in_f || in_m);
         chk1("rnd_iord", bus.iord, in_m);
         chk1("rnd_ir_write", bus.ir_write, k == fw);
         chk1("rnd_mem_we", bus.mem_we, in_m && is_st);
         chk1("rnd_reg_write", bus.reg_write, wr && last);
         chk1("rnd_done", bus.instr_done, last);
         chk1("rnd_trap", bus.trap, 1'b0);
      end
      exp_ir = exp_ir + 1'b1;
   endtask

   logic [6:0] legal_ops[6];
   logic [6:0] ill_ops[3];

   initial begin
      legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
      ill_ops   = '{7'b1111111, 7'b0000000, 7'b0110111};

      // R-type, all ready
      add(7'b0110011, 1'b1, o_fetch(1'b1));
      add(7'b0110011, 1'b0, o_dec(1'b0));
      add(7'b0110011, 1'b0, o_exec(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0));
      add(7'b0110011, 1'b1, o_wb(1'b0));
      // LD with three MEM stalls: 8 cycles
      add(7'b0000011, 1'b1, o_fetch(1'b1));
      add(7'b0000011, 1'b1, o_dec(1'b0));
      add(7'b0000011, 1'b0, o_exec(1'b0, 2'b10, 3'b010, 1'b0, 1'b0, 2'b00, 1'b0));
      add(7'b0000011, 1'b0, o_mem(1'b0, 1'b0));
      add(7'b0000011, 1'b0, o_mem(1'b0, 1'b0));
      add(7'b0000011, 1'b0, o_mem(1'b0, 1'b0));
      add(7'b0000011, 1'b1, o_mem(1'b0, 1'b0));
      add(7'b0000011, 1'b0, o_wb(1'b1));
      // ST with one FETCH stall
      add(7'b0100011, 1'b0, o_fetch(1'b0));
      add(7'b0100011, 1'b1, o_fetch(1'b1));
      add(7'b0100011, 1'b1, o_dec(1'b0));
      add(7'b0100011, 1'b1, o_exec(1'b0, 2'b10, 3'b010, 1'b0, 1'b0, 2'b00, 1'b0));
      add(7'b0100011, 1'b1, o_mem(1'b1, 1'b1));
      // BR then JAL back-to-back
      add(7'b1100011, 1'b1, o_fetch(1'b1));
      add(7'b1100011, 1'b0, o_dec(1'b0));
      add(7'b1100011, 1'b1, o_exec(1'b0, 2'b00, 3'b011, 1'b0, 1'b1, 2'b01, 1'b1));
      add(7'b1101111, 1'b1, o_fetch(1'b1));
      add(7'b1101111, 1'b1, o_dec(1'b0));
      add(7'b1101111, 1'b0, o_exec(1'b0, 2'b00, 3'b000, 1'b1, 1'b0, 2'b10, 1'b1));
      // I-type
      add(7'b0010011, 1'b1, o_fetch(1'b1));
      add(7'b0010011, 1'b1, o_dec(1'b0));
      add(7'b0010011, 1'b1, o_exec(1'b0, 2'b10, 3'b001, 1'b0, 1'b0, 2'b00, 1'b0));
      add(7'b0010011, 1'b0, o_wb(1'b0));
      // Illegal opcode
      add(7'b1111111, 1'b1, o_fetch(1'b1));
`ifdef MC_CTRL_TRAP_EN
      add(7'b1111111, 1'b1, o_dec(1'b0));
      add(7'b1111111, 1'b1, 18'd1);
      add(7'b0110011, 1'b1, 18'd1);
      add(7'b0110011, 1'b0, 18'd1);
`else
      add(7'b1111111, 1'b1, o_dec(1'b1));
      add(7'b0110011, 1'b0, o_fetch(1'b0));
`endif

      // Table-driven section
      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         bus.opcode    = tbl[i].opc;
         bus.mem_ready = tbl[i].rdy;
         #1;
         chk($sformatf("vec%0d_outputs", i), 32'(act), 32'(tbl[i].exp));
         chk($sformatf("vec%0d_instret", i), 32'(instret), 32'(exp_ir));
         if (tbl[i].exp[1]) exp_ir = exp_ir + 1'b1;
      end

      // Randomized section against the latency model
      do_reset();
      for (int n = 0; n < 40; n++) begin
         logic [6:0] opc;
`ifdef MC_CTRL_TRAP_EN
         opc = legal_ops[$urandom_range(0, 5)];
`else
         if ($urandom_range(0, 7) == 0) opc = ill_ops[$urandom_range(0, 2)];
         else                           opc = legal_ops[$urandom_range(0, 5)];
`endif
         run_instr(opc, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end

      // Reset during the MEM cycle of a store
      @(negedge clk);
      bus.opcode    = 7'b0100011;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      chk1("abort_pre_mem_we", bus.mem_we, 1'b1);
      chk1("abort_pre_mem_req", bus.mem_req, 1'b1);
      chk("abort_pre_instret", 32'(instret), 32'(exp_ir));
      rst_n = 1'b0;
      #1;
      chk1("abort_mem_we", bus.mem_we, 1'b0);
      chk1("abort_mem_req", bus.mem_req, 1'b0);
      chk("abort_state", 32'(dbg_state), 32'(ST_RST));
      chk("abort_instret", 32'(instret), 32'd0);
      @(posedge clk);
      #1;
      chk("abort_next_cycle_outputs", 32'(act), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
